// File: rtl/gpr_wport_arb_pkg.sv
// Shared widths, defaults and helpers for the GPR write-port arbiter.
package gpr_wport_arb_pkg;

   localparam int unsigned GprAw            = 5;
   localparam int unsigned GprDw            = 32;
   localparam int unsigned GprBw            = 4;
   localparam int unsigned NumGpr           = 32;
   localparam int unsigned StarveMaxDefault = 4;

   typedef struct packed {
      logic [GprAw-1:0] addr;
      logic [GprDw-1:0] data;
   } lu_entry_t;

   // One-hot register mask; x0 is hardwired so it never gets a bit.
   function automatic logic [NumGpr-1:0] gpr_bit(input logic [GprAw-1:0] addr);
      logic [NumGpr-1:0] mask;
      mask = '0;
      if (addr != '0) mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO with full/empty flags; head is visible combinationally.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];

   // A push at full is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/gpr_wport_arb.sv
// Shares the GPR write port between WB and the long-latency unit, tracks pending LU
// destinations and requests ID stalls on hazards or when buffered results starve.
module gpr_wport_arb
   import gpr_wport_arb_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GprBw-1:0]  pipe_we,
   input  logic [GprAw-1:0]  pipe_waddr,
   input  logic [GprDw-1:0]  pipe_wdata,
   input  logic              lu_issue,
   input  logic [GprAw-1:0]  lu_issue_addr,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [GprAw-1:0]  lu_waddr,
   input  logic [GprDw-1:0]  lu_wdata,
   input  logic              id_ren1,
   input  logic              id_ren2,
   input  logic [GprAw-1:0]  id_raddr1,
   input  logic [GprAw-1:0]  id_raddr2,
   input  logic              id_wen,
   input  logic [GprAw-1:0]  id_waddr,
   output logic [GprBw-1:0]  we,
   output logic [GprAw-1:0]  waddr,
   output logic [GprDw-1:0]  wdata,
   output logic              stallreq,
   output logic [NumGpr-1:0] pending_o
);

   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

   lu_entry_t           push_entry, head;
   logic                fifo_full, fifo_empty, push, pop, pipe_busy;
   logic [CntW-1:0]     starve_q, starve_d;
   logic                drain_q, drain_d, drain_act, hazard;
   logic [NumGpr-1:0]   pend_q, pend_d;

   assign push_entry = '{addr: lu_waddr, data: lu_wdata};
   assign pipe_busy  = |pipe_we;
   assign lu_ready   = !fifo_full && !rst;
   assign push       = lu_valid && lu_ready;
   assign pop        = !rst && !pipe_busy && !fifo_empty;
   assign pending_o  = pend_q;

   sync_fifo #(
      .Width ($bits(lu_entry_t)),
      .Depth (DEPTH)
   ) u_lu_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // WB always wins the port; a write to x0 is suppressed but still consumes the entry.
   always_comb begin
      waddr = pipe_waddr;
      wdata = pipe_wdata;
      we    = pipe_we;
      if (!pipe_busy) begin
         waddr = head.addr;
         wdata = head.data;
         we    = pop ? {GprBw{1'b1}} : '0;
      end
      if (waddr == '0 || rst) we = '0;
   end

   always_comb begin
      hazard = ((gpr_bit(id_raddr1) & pend_q) != '0 && id_ren1) ||
               ((gpr_bit(id_raddr2) & pend_q) != '0 && id_ren2) ||
               ((gpr_bit(id_waddr) & pend_q) != '0 && id_wen) ||
               ((gpr_bit(lu_issue_addr) & pend_q) != '0 && lu_issue);
      drain_act = (drain_q || starve_q == CntW'(STARVE_MAX)) && !fifo_empty;
      stallreq  = !rst && (hazard || drain_act);
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (pipe_busy && starve_q != CntW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
      drain_d = drain_act;

      // Clear first so that a same-cycle issue to the same register wins.
      pend_d = pend_q;
      if (pop) pend_d = pend_d & ~gpr_bit(head.addr);
      if (lu_issue && !stallreq) pend_d = pend_d | gpr_bit(lu_issue_addr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         drain_q  <= 1'b0;
         pend_q   <= '0;
      end else begin
         starve_q <= starve_d;
         drain_q  <= drain_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Directed bench for gpr_wport_arb: expected LU writes are queued on handshake and
// popped when the write port should carry them.
module tb_gpr_wport_arb;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_wr_t;

   logic        clk;
   logic        rst;
   logic [3:0]  pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_issue;
   logic [4:0]  lu_issue_addr;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        id_ren1, id_ren2;
   logic [4:0]  id_raddr1, id_raddr2;
   logic        id_wen;
   logic [4:0]  id_waddr;
   logic [3:0]  we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        stallreq;
   logic [31:0] pending_o;

   int checks = 0;
   int errors = 0;
   exp_wr_t exp_q[$];

   gpr_wport_arb #(
      .DEPTH      (2),
      .STARVE_MAX (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_we       (pipe_we),
      .pipe_waddr    (pipe_waddr),
      .pipe_wdata    (pipe_wdata),
      .lu_issue      (lu_issue),
      .lu_issue_addr (lu_issue_addr),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_waddr      (lu_waddr),
      .lu_wdata      (lu_wdata),
      .id_ren1       (id_ren1),
      .id_ren2       (id_ren2),
      .id_raddr1     (id_raddr1),
      .id_raddr2     (id_raddr2),
      .id_wen        (id_wen),
      .id_waddr      (id_waddr),
      .we            (we),
      .waddr         (waddr),
      .wdata         (wdata),
      .stallreq      (stallreq),
      .pending_o     (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic lu_push(input logic [4:0] addr, input logic [31:0] data);
      exp_wr_t e;
      lu_valid = 1'b1;
      lu_waddr = addr;
      lu_wdata = data;
      e.addr   = addr;
      e.data   = data;
      exp_q.push_back(e);
   endtask

   // Compare the write port against the oldest expected LU write.
   task automatic chk_lu_write(input string tag);
      exp_wr_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_we"}, 32'(we), (e.addr != 5'd0) ? 32'hF : 32'h0);
         chk({tag, "_waddr"}, 32'(waddr), 32'(e.addr));
         if (e.addr != 5'd0) chk({tag, "_wdata"}, wdata, e.data);
      end
   endtask

   task automatic idle_inputs();
      pipe_we = '0; pipe_waddr = '0; pipe_wdata = '0;
      lu_issue = 1'b0; lu_issue_addr = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
      id_ren1 = 1'b0; id_ren2 = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
      id_wen = 1'b0; id_waddr = '0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      pipe_we = 4'hF; pipe_waddr = 5'd1;
      tick(); tick();
      settle();
      chk("rst_lu_ready", 32'(lu_ready), 32'h0);
      chk("rst_we", 32'(we), 32'h0);
      chk("rst_stallreq", 32'(stallreq), 32'h0);
      chk("rst_pending", pending_o, 32'h0);
      rst = 1'b0;
      idle_inputs();
      tick();
      settle();
      chk("post_rst_lu_ready", 32'(lu_ready), 32'h1);
      chk("post_rst_we", 32'(we), 32'h0);

      // Issue to x5, result returns with the pipe idle.
      lu_issue = 1'b1; lu_issue_addr = 5'd5;
      settle();
      chk("issue5_stall", 32'(stallreq), 32'h0);
      tick();
      lu_issue = 1'b0;
      id_ren1 = 1'b1; id_raddr1 = 5'd5;
      settle();
      chk("pend5_set", pending_o, 32'h20);
      chk("raw5_stall", 32'(stallreq), 32'h1);
      lu_push(5'd5, 32'hDEAD_BEEF);
      tick();
      lu_valid = 1'b0;
      settle();
      chk("raw5_stall_wb", 32'(stallreq), 32'h1);
      chk_lu_write("lu5");
      tick();
      settle();
      chk("pend5_clear", pending_o, 32'h0);
      chk("raw5_release", 32'(stallreq), 32'h0);
      chk("idle_we", 32'(we), 32'h0);
      id_ren1 = 1'b0;

      // Starvation: entry for x7 held off by a busy pipe.
      pipe_we = 4'hF; pipe_waddr = 5'd10; pipe_wdata = 32'h1234_5678;
      lu_push(5'd7, 32'h0000_0077);
      tick();
      lu_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk($sformatf("starve_stall_%0d", i), 32'(stallreq), (i >= 4) ? 32'h1 : 32'h0);
         chk($sformatf("pipe_we_%0d", i), 32'(we), 32'hF);
         chk($sformatf("pipe_waddr_%0d", i), 32'(waddr), 32'd10);
         tick();
      end
      chk("pipe_wdata", wdata, 32'h1234_5678);
      pipe_we = 4'h0;
      settle();
      chk("drain_stall_pop", 32'(stallreq), 32'h1);
      chk_lu_write("lu7");
      tick();
      settle();
      chk("drain_release", 32'(stallreq), 32'h0);

      // Fill the buffer behind a busy pipe, then drain in order.
      pipe_we = 4'hF;
      lu_push(5'd11, 32'hAAAA_0011);
      settle();
      chk("fill_ready0", 32'(lu_ready), 32'h1);
      tick();
      lu_push(5'd12, 32'hBBBB_0012);
      settle();
      chk("fill_ready1", 32'(lu_ready), 32'h1);
      tick();
      lu_valid = 1'b1; lu_waddr = 5'd13; lu_wdata = 32'hCCCC_0013;
      settle();
      chk("full_ready_a", 32'(lu_ready), 32'h0);
      tick();
      settle();
      chk("full_ready_b", 32'(lu_ready), 32'h0);
      tick();
      pipe_we = 4'h0;
      settle();
      chk("full_ready_prepop", 32'(lu_ready), 32'h0);
      chk_lu_write("lu11");
      tick();
      settle();
      chk("ready_after_pop", 32'(lu_ready), 32'h1);
      lu_push(5'd13, 32'hCCCC_0013);
      settle();
      chk_lu_write("lu12");
      tick();
      lu_valid = 1'b0;
      settle();
      chk_lu_write("lu13");
      tick();
      settle();
      chk("fill_empty_we", 32'(we), 32'h0);
      chk("fill_empty_stall", 32'(stallreq), 32'h0);

      // WAW and issue hazards against a pending x9.
      lu_issue = 1'b1; lu_issue_addr = 5'd9;
      tick();
      settle();
      chk("issue9_hazard", 32'(stallreq), 32'h1);
      tick();
      lu_issue = 1'b0;
      id_wen = 1'b1; id_waddr = 5'd9;
      settle();
      chk("waw9_stall", 32'(stallreq), 32'h1);
      id_wen = 1'b0; id_ren2 = 1'b1; id_raddr2 = 5'd9;
      settle();
      chk("raw9_ren2_stall", 32'(stallreq), 32'h1);
      id_ren2 = 1'b0; id_wen = 1'b1;
      lu_push(5'd9, 32'h0000_0099);
      tick();
      lu_valid = 1'b0;
      settle();
      chk("waw9_stall_wb", 32'(stallreq), 32'h1);
      chk_lu_write("lu9");
      tick();
      settle();
      chk("waw9_release", 32'(stallreq), 32'h0);
      chk("pend9_clear", pending_o, 32'h0);
      id_wen = 1'b0;

      // x0 never pends or writes, but its entry still drains.
      lu_issue = 1'b1; lu_issue_addr = 5'd0;
      settle();
      chk("issue0_stall", 32'(stallreq), 32'h0);
      tick();
      lu_issue = 1'b0;
      settle();
      chk("pend0_unset", pending_o, 32'h0);
      lu_push(5'd0, 32'h0000_0005);
      tick();
      lu_valid = 1'b0;
      settle();
      chk_lu_write("lu0");
      tick();
      lu_push(5'd4, 32'h0000_0044);
      tick();
      lu_valid = 1'b0;
      settle();
      chk_lu_write("lu4_after_x0");
      tick();

      // Pipe byte enables pass through; pipe write to x0 suppressed.
      pipe_we = 4'h3; pipe_waddr = 5'd8; pipe_wdata = 32'hFEED_0008;
      settle();
      chk("pipe_partial_we", 32'(we), 32'h3);
      pipe_waddr = 5'd0;
      settle();
      chk("pipe_x0_we", 32'(we), 32'h0);
      pipe_we = 4'h0;

      // Same-cycle clear and set of x3: set wins.
      lu_push(5'd3, 32'h0000_0033);
      tick();
      lu_valid = 1'b0;
      lu_issue = 1'b1; lu_issue_addr = 5'd3;
      settle();
      chk("issue3_nostall", 32'(stallreq), 32'h0);
      chk_lu_write("lu3");
      tick();
      lu_issue = 1'b0;
      settle();
      chk("pend3_set_wins", pending_o, 32'h8);

      // Reset mid-stream with a buffered entry and a pending bit.
      pipe_we = 4'hF; pipe_waddr = 5'd10;
      lu_valid = 1'b1; lu_waddr = 5'd6; lu_wdata = 32'h0000_0066;
      tick();
      lu_valid = 1'b0;
      id_ren1 = 1'b1; id_raddr1 = 5'd3;
      settle();
      chk("pre_rst_stall", 32'(stallreq), 32'h1);
      rst = 1'b1;
      pipe_we = 4'h0;
      settle();
      chk("mid_rst_stall", 32'(stallreq), 32'h0);
      chk("mid_rst_we", 32'(we), 32'h0);
      chk("mid_rst_ready", 32'(lu_ready), 32'h0);
      tick();
      rst = 1'b0;
      settle();
      chk("after_rst_pending", pending_o, 32'h0);
      chk("after_rst_we", 32'(we), 32'h0);
      chk("after_rst_ready", 32'(lu_ready), 32'h1);
      chk("after_rst_stall", 32'(stallreq), 32'h0);
      exp_q.delete();
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpr_wport_arb.md
# gpr_wport_arb

Write-port arbiter and pending-write scoreboard for the GPR file. Shares the file's single byte-enabled write port between the in-order pipeline WB stage and a long-latency unit (LU) that returns results out of band. It buffers LU results, tracks destinations with writes outstanding, and raises a stall request to ID on any read or write hazard against them. It sits between MEM/WB, the LU and the regfile write port, and feeds the pipeline stall controller.

## Interface
- DEPTH, 2: LU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4: consecutive denied cycles before the buffer forces a drain
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pipe_we  in  4  WB byte enables; nonzero means WB writes this cycle
- pipe_waddr / pipe_wdata  in  5 / 32  WB destination / data
- lu_issue  in  1  ID issues an LU op this cycle (only counted when stallreq=0)
- lu_issue_addr  in  5  its destination
- lu_valid / lu_ready  in / out  1 / 1  LU result handshake; transfer when both high
- lu_waddr / lu_wdata  in  5 / 32  LU result destination / data
- id_ren1, id_ren2  in  1  ID read enables
- id_raddr1, id_raddr2  in  5  ID read addresses
- id_wen / id_waddr  in  1 / 5  ID instruction writes a GPR / its destination
- we / waddr / wdata  out  4 / 5 / 32  to regfile write port
- stallreq  out  1  hazard stall to ID
- pending_o  out  32  scoreboard, bit n = GPR n has an outstanding LU write

## Operation
- Scoreboard `pend[31:0]`: set bit `lu_issue_addr` when lu_issue && !stallreq && addr≠0; clear bit when that register's buffered LU result is written to the regfile. Set and clear of the same bit in one cycle: set wins. Bit 0 is never set.
- Buffer: FIFO of {waddr, wdata}, DEPTH entries. Push on lu_valid && lu_ready. lu_ready = !full. Push and pop in the same cycle are allowed at full, but lu_ready still reflects pre-pop fullness.
- Arbitration each cycle, with priority:
  - pipe_we≠0: the write port passes pipe_we/waddr/wdata through. The buffer is denied.
  - otherwise, if the buffer is nonempty: pop the head and drive we=4'hF with the head's addr/data.
  - otherwise: we=0.
- we is forced to 0 whenever the selected waddr=0; a pop still occurs.
- Starvation counter: increments on each cycle the buffer is nonempty and denied, and clears on a pop or when the buffer is empty. It saturates at STARVE_MAX.
- Drain mode: entered when the counter reaches STARVE_MAX. It holds stallreq high until the buffer is empty.
- stallreq is high if any of the following holds:
  - (id_ren1 && pend[id_raddr1])
  - (id_ren2 && pend[id_raddr2])
  - (id_wen && pend[id_waddr]), which prevents WAW: a short op must not retire before the LU write
  - (lu_issue && pend[lu_issue_addr])
  - drain mode
- Address 0 never hazards.

## Timing
- Reset values: pend=0, FIFO empty, counter=0, drain=0, lu_ready=0 during rst and 1 from the first cycle after it, stallreq=0, we=0.
- Write port is combinational from pipe_* and the FIFO head, so WB writes carry zero added latency.
- LU result accepted at edge N is written to the regfile no earlier than cycle N+1. Its pend bit is clear from cycle N+2.
- stallreq is combinational from pend, the ID inputs and drain. No one-cycle bypass from the LU exists: a dependent reader stalls until the clear is visible.
- rst mid-operation discards the buffered results and pending bits. Pipeline flush on reset is the owner's responsibility.

## Structure
- Shared package: GPR address width (5), data width (32), byte-enable width (4), and the STARVE_MAX default.
- One sub-module, `sync_fifo`: parameterized width/depth, registered, with full/empty outputs. Reused for other buffers.
- The scoreboard, arbiter and starvation counter stay in this module.

## Test plan
- Reset, then lu_issue addr 5, then LU returns 5=0xDEAD_BEEF with pipe idle:
  - we=F, waddr=5 the cycle after acceptance
  - pend[5] clears one cycle later
  - stallreq high on id_raddr1=5 until then
- Buffer entry for addr 7 while pipe_we=F for 10 cycles, STARVE_MAX=4: stallreq rises after 4 denied cycles; the entry is written on the first pipe_we=0 cycle, after which stallreq drops.
- DEPTH=2 with two LU results buffered and the pipe busy: lu_ready=0. A third lu_valid is held until a pop, and no data is lost or reordered.
- id_wen with id_waddr=9 while pend[9]=1: stallreq=1. LU write to 9 completes, then stallreq=0 the next cycle.
- lu_issue_addr=0 and an LU result to addr 0: pend unchanged, we=0, FIFO pops.
- Same-cycle clear of pend[3] with a new issue to 3: pend[3] stays 1. Assert rst mid-stream: all state returns to its reset values.
